// File: rtl/string_hw_pkg.sv
// Shared types and constants for the String_HW sequencer and its buffers.
package string_hw_pkg;

  localparam int WORD_BYTES = 4;

  typedef logic [0:WORD_BYTES-1][7:0] str_word_t;

  typedef enum logic [2:0] {
    OP_CMP   = 3'd0,
    OP_UPPER = 3'd1,
    OP_LOWER = 3'd2
  } op_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    CAPTURE = 3'd2,
    RELEASE = 3'd3,
    FINISH  = 3'd4
  } state_e;

  // A final-word length outside 1..WORD_BYTES means a full word.
  function automatic logic [2:0] eff_len(input logic [2:0] len);
    if (len == 3'd0 || len > 3'(WORD_BYTES)) begin
      return 3'(WORD_BYTES);
    end
    return len;
  endfunction

endpackage

// File: rtl/string_word_buf.sv
// Word register file: LANES 32-bit words per entry on one shared address,
// one write port and a registered write-first read port.
module string_word_buf
  import string_hw_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter int  LANES = 1,
  localparam int AW    = $clog2(DEPTH),
  localparam int DW    = 8 * WORD_BYTES * LANES
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Forwarding the write data lets a write and a read of the same entry in
  // one cycle return the new word, so a load issued with start is seen.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rdata_q <= '0;
    end else if (we_i && (waddr_i == raddr_i)) begin
      rdata_q <= wdata_i;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/string_hw_sequencer.sv
// Initiator-side controller for the String_HW engine: feeds buffered words
// one per go/done handshake and collects compare verdicts or converted words.
module string_hw_sequencer
  import string_hw_pkg::*;
#(
  parameter int  MAX_WORDS   = 8,
  parameter int  TIMEOUT_CYC = 255,
  localparam int AW          = $clog2(MAX_WORDS)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [31:0]   wr_a_i,
  input  logic [31:0]   wr_b_i,
  input  logic          start_i,
  input  logic [2:0]    op_i,
  input  logic [AW:0]   num_words_i,
  input  logic [2:0]    last_len_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          error_o,
  output logic          cmp_equal_o,
  output logic [AW:0]   words_done_o,
  input  logic [AW-1:0] rd_addr_i,
  output logic [31:0]   rd_data_o,
  output logic          eng_go_o,
  output logic [2:0]    eng_index_o,
  output logic [31:0]   eng_a_o,
  output logic [31:0]   eng_b_o,
  output logic [2:0]    eng_length_o,
  input  logic          eng_done_i,
  input  logic [31:0]   eng_result_i
);

  localparam int          CW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [AW:0] NUM_MAX  = (AW + 1)'(MAX_WORDS);

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic [AW:0]   num_q, num_d;
  logic [2:0]    len_q, len_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          cmp_q, cmp_d;
  logic [AW:0]   words_q, words_d;

  logic          go;
  logic          result_we;
  logic          is_last;
  logic          ab_we;
  logic [63:0]   ab_rdata;

  assign is_last = ({1'b0, ptr_q} == (num_q - (AW + 1)'(1)));
  assign ab_we   = wr_en_i && (state_q == IDLE);

  // A/B read address follows the next pointer so the word is ready in ISSUE.
  string_word_buf #(
    .DEPTH (MAX_WORDS),
    .LANES (2)
  ) u_ab_buf (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .we_i    (ab_we),
    .waddr_i (wr_addr_i),
    .wdata_i ({wr_a_i, wr_b_i}),
    .raddr_i (ptr_d),
    .rdata_o (ab_rdata)
  );

  string_word_buf #(
    .DEPTH (MAX_WORDS),
    .LANES (1)
  ) u_result_buf (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .we_i    (result_we),
    .waddr_i (ptr_q),
    .wdata_i (eng_result_i),
    .raddr_i (rd_addr_i),
    .rdata_o (rd_data_o)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      num_q   <= '0;
      len_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      cmp_q   <= 1'b0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      num_q   <= num_d;
      len_q   <= len_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      cmp_q   <= cmp_d;
      words_q <= words_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    num_d     = num_q;
    len_d     = len_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = error_q;
    cmp_d     = cmp_q;
    words_d   = words_q;
    go        = 1'b0;
    result_we = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          op_d    = op_i;
          num_d   = num_words_i;
          len_d   = last_len_i;
          error_d = 1'b0;
          words_d = '0;
          cmp_d   = 1'b1;
          busy_d  = 1'b1;
          ptr_d   = '0;
          cnt_d   = '0;
          if (op_i > 3'(OP_LOWER) || num_words_i > NUM_MAX) begin
            error_d = 1'b1;
            state_d = FINISH;
          end else if (num_words_i == '0) begin
            state_d = FINISH;
          end else begin
            state_d = ISSUE;
          end
        end
      end

      ISSUE: begin
        go = 1'b1;
        if (eng_done_i) begin
          state_d = CAPTURE;
        end else if (cnt_q == TO_LAST) begin
          error_d = 1'b1;
          cnt_d   = '0;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      CAPTURE: begin
        go = 1'b1;
        if (op_q == 3'(OP_CMP)) begin
          cmp_d = cmp_q & (eng_result_i == 32'd1);
        end else begin
          result_we = 1'b1;
        end
        words_d = words_q + (AW + 1)'(1);
        cnt_d   = '0;
        state_d = RELEASE;
      end

      // A compare stops at the first mismatching word.
      RELEASE: begin
        if (!eng_done_i) begin
          cnt_d = '0;
          if (is_last || error_q || (op_q == 3'(OP_CMP) && !cmp_q)) begin
            state_d = FINISH;
          end else begin
            ptr_d   = ptr_q + AW'(1);
            state_d = ISSUE;
          end
        end else if (cnt_q == TO_LAST) begin
          error_d = 1'b1;
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign cmp_equal_o  = cmp_q;
  assign words_done_o = words_q;

  assign eng_go_o     = go;
  assign eng_index_o  = go ? op_q : 3'd0;
  assign eng_a_o      = go ? ab_rdata[63:32] : 32'd0;
  assign eng_b_o      = go ? ab_rdata[31:0] : 32'd0;
  assign eng_length_o = go ? (is_last ? eff_len(len_q) : 3'(WORD_BYTES)) : 3'd0;

endmodule

// File: doc/string_hw_sequencer.md
Name: string_hw_sequencer

Overview:
Initiator-side controller for the String_HW engine. It drives the engine's go/index/A/B/length inputs and consumes its done/result outputs. Host software (Nios II) loads strings of up to MAX_WORDS 4-byte words into internal buffers, then issues one start. The sequencer feeds the engine one word per go/done handshake, stores or accumulates the results, and reports completion, the compare verdict and any error.

Parameters:
MAX_WORDS, 8, depth of the A/B/result word buffers (power of 2).
TIMEOUT_CYC, 255, maximum cycles to wait for eng_done after raising eng_go.
AW, $clog2(MAX_WORDS), buffer address width (derived; do not override).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
wr_en  in  1  buffer write strobe
wr_addr  in  AW  word index to write
wr_a  in  32  word of string A (packed [0:3][7:0], SV string-literal order)
wr_b  in  32  word of string B
start  in  1  single-cycle request to begin an operation
op  in  3  0 = compare, 1 = to-upper, 2 = to-lower
num_words  in  AW+1  number of words to process, 0..MAX_WORDS
last_len  in  3  valid bytes in the final word, 1..4
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle completion pulse
error  out  1  sticky until next start: bad op, bad num_words, or timeout
cmp_equal  out  1  compare verdict, valid when done pulses
words_done  out  AW+1  words completed
rd_addr  in  AW  result buffer read address
rd_data  out  32  result word; registered, 1-cycle latency
eng_go  out  1  engine go
eng_index  out  3  engine operation select
eng_a  out  32  engine operand A
eng_b  out  32  engine operand B
eng_length  out  3  engine byte count
eng_done  in  1  engine done
eng_result  in  32  engine result

Behaviour:
- Reset: every output is 0, and the FSM returns to IDLE on the next edge.
  - Reset mid-operation forces eng_go low on the following cycle.
  - Buffers are not cleared.
- FSM states: IDLE, ISSUE, CAPTURE, RELEASE, FINISH.
- IDLE:
  - start latches op, num_words and last_len; clears error, words_done and cmp_equal (set to 1); sets busy.
  - If op > 2 or num_words > MAX_WORDS: set error and go to FINISH.
  - If num_words == 0: go to FINISH with cmp_equal = 1.
  - Otherwise go to ISSUE with word pointer = 0.
  - start while busy is ignored. wr_en is honoured only in IDLE.
- ISSUE:
  - eng_go = 1; eng_a/eng_b = buffer[ptr]; eng_index = op.
  - eng_length = 4, except the last word, which uses last_len. last_len of 0 or >4 is treated as 4.
  - The first eng_go = 1 appears the cycle after start (1-cycle issue latency).
  - Stay in ISSUE until eng_done = 1, then go to CAPTURE.
  - A cycle counter runs in ISSUE. When it reaches TIMEOUT_CYC: drop eng_go, set error, go to RELEASE.
- CAPTURE (1 cycle; eng_go held high):
  - op 0: cmp_equal &= (eng_result == 1).
  - ops 1/2: result_buf[ptr] = eng_result.
  - Increment words_done, then go to RELEASE.
- RELEASE:
  - eng_go = 0; wait for eng_done = 0, with the same timeout rule.
  - Then go to FINISH if:
    - ptr was the last word,
    - error is set, or
    - op 0 and cmp_equal == 0 (early exit on first mismatch).
  - Otherwise ptr++ and go to ISSUE.
- FINISH: done = 1 for one cycle, busy = 0, then IDLE. cmp_equal and words_done hold until the next start.
- rd_data = result_buf[rd_addr], registered, readable at any time. Entries not written by the current op keep stale data.
- Simultaneous wr_en and start in IDLE: the write commits before the operation reads the buffer.

Decomposition:
- Package string_hw_pkg holds:
  - op enum: OP_CMP = 0, OP_UPPER = 1, OP_LOWER = 2.
  - String word type: logic [0:3][7:0].
  - FSM state enum.
  - Constant WORD_BYTES = 4.
- One sub-module, string_word_buf: dual 32-bit register file with one write port and one registered read port. It is instantiated for A/B (shared address) and for results.

Test Plan:
1. Compare, matching strings.
   - Stimulus: A = B = {"abcd", "efgh", "ij"}, num_words = 3, last_len = 2, op = 0.
   - Required: exactly 3 go/done handshakes; done pulse with cmp_equal = 1, words_done = 3, error = 0.
2. Compare, early mismatch.
   - Stimulus: A = {"abcd", "wxyz", "ij"}, B = {"abcd", "wxya", "ij"}.
   - Required: cmp_equal = 0, words_done = 2, no third eng_go.
3. To-upper.
   - Stimulus: A = {"AbCd", "ef"}, num_words = 2, last_len = 2, op = 1.
   - Required: rd_data[0] = "ABCD", rd_data[1] = "EF"; eng_length sequence 4, 2.
4. To-lower.
   - Stimulus: A = {"ABCD"}, op = 2.
   - Required: rd_data[0] = "abcd".
   - Also: start pulsed during busy is ignored, and eng_go returns to 0 between words.
5. Boundaries and errors.
   - num_words = 0: done the cycle after FSM enters FINISH, cmp_equal = 1, no eng_go.
   - op = 5: error = 1, no eng_go.
   - num_words = 9: error = 1, no eng_go.
6. Timeout and reset.
   - Engine stubbed never to assert done: error = 1 after 255 cycles in ISSUE, followed by a done pulse.
   - Reset asserted mid-ISSUE: eng_go = 0, busy = 0 next cycle; a subsequent op 1 completes correctly.
